dsp_addsub_arbiter: RTL and testbench



---
 rtl/dsp_addsub_arbiter_pkg.sv | 29 ++
 rtl/rr_pick.sv | 34 +++
 rtl/dsp_addsub_arbiter.sv | 153 +++++++++++++++
 tb/tb_dsp_addsub_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/dsp_addsub_arbiter_pkg.sv
// Shared constants and types for the round-robin arbiter in front of the single DSP add/sub unit.
// Contains FSM state codes, op codes, the latched-command struct and the signed-overflow helper.
package dsp_addsub_arbiter_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef struct packed {
    logic              op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } cmd_t;

  // Two's complement overflow from the operand and result sign bits.
  function automatic logic signed_ovf(input logic op, input logic a31,
                                      input logic b31, input logic r31);
    if (op == OP_ADD) begin
      return (a31 == b31) && (r31 != a31);
    end
    return (a31 != b31) && (r31 != a31);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first set request at or after ptr wins (wrapping mod N).
// Produces a one-hot grant, its index, and an any-request flag.
module rr_pick #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_idx,
  output logic            any
);

  // Scan from the farthest offset down so the nearest requester overwrites last.
  always_comb begin
    int idx;
    gnt     = '0;
    gnt_idx = '0;
    any     = |req;
    idx     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N) begin
        idx = idx - N;
      end
      if (req[ID_W'(idx)]) begin
        gnt              = '0;
        gnt[ID_W'(idx)]  = 1'b1;
        gnt_idx          = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/dsp_addsub_arbiter.sv
// Shares one combinational 32-bit DSP add/sub between NUM_REQ requesters, round-robin arbitrated.
// Optional macro DSP_ARB_OVF_EN adds a registered signed-overflow flag rsp_ovf.
module dsp_addsub_arbiter
  import dsp_addsub_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_op,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [DATA_W-1:0]         dsp_in1,
  output logic [DATA_W-1:0]         dsp_in2,
  output logic                      dsp_add_sub,
  input  logic [DATA_W-1:0]         dsp_out,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [ID_W-1:0]           rsp_id
`ifdef DSP_ARB_OVF_EN
  ,
  output logic                      rsp_ovf
`endif
);

  logic [DATA_W-1:0] a_arr [NUM_REQ];
  logic [DATA_W-1:0] b_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign a_arr[gi] = req_a[gi*DATA_W +: DATA_W];
      assign b_arr[gi] = req_b[gi*DATA_W +: DATA_W];
    end
  endgenerate

  logic [1:0]        state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  cmd_t              cmd_q, cmd_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
`ifdef DSP_ARB_OVF_EN
  logic              ovf_q, ovf_d;
`endif

  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic               any_req;
  logic               rsp_hs;
  logic               grant;

  rr_pick #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_pick (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any_req)
  );

  // A new grant may overlap the response handshake so HOLD can go straight back to ISSUE.
  assign rsp_hs    = rsp_valid_q & rsp_ready;
  assign grant     = !rst && any_req &&
                     ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && rsp_hs));
  assign req_ready = grant ? gnt : '0;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    cmd_d       = cmd_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
`ifdef DSP_ARB_OVF_EN
    ovf_d       = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (grant) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        rsp_data_d  = dsp_out;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
`ifdef DSP_ARB_OVF_EN
        ovf_d       = signed_ovf(cmd_q.op, cmd_q.a[DATA_W-1], cmd_q.b[DATA_W-1],
                                 dsp_out[DATA_W-1]);
`endif
        state_d     = ST_HOLD;
      end
      ST_HOLD: begin
        if (rsp_hs) begin
          rsp_valid_d = 1'b0;
          state_d     = grant ? ST_ISSUE : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (grant) begin
      cmd_d.op = req_op[gnt_idx];
      cmd_d.a  = a_arr[gnt_idx];
      cmd_d.b  = b_arr[gnt_idx];
      id_d     = gnt_idx;
      ptr_d    = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      cmd_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
`ifdef DSP_ARB_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      cmd_q       <= cmd_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
`ifdef DSP_ARB_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign dsp_in1     = cmd_q.a;
  assign dsp_in2     = cmd_q.b;
  assign dsp_add_sub = cmd_q.op;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_id      = rsp_id_q;
`ifdef DSP_ARB_OVF_EN
  assign rsp_ovf     = ovf_q;
`endif

endmodule

// File: tb/tb_dsp_addsub_arbiter.sv
// Directed bench for dsp_addsub_arbiter with a behavioural DSP add/sub model.
// Overflow checks are compiled in when DSP_ARB_OVF_EN is defined.
module tb_dsp_addsub_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NUM_REQ-1:0]    req_valid = '0;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    req_op = '0;
  logic [NUM_REQ*32-1:0] req_a = '0;
  logic [NUM_REQ*32-1:0] req_b = '0;
  logic [31:0]           dsp_in1, dsp_in2, dsp_out;
  logic                  dsp_add_sub;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b0;
  logic [31:0]           rsp_data;
  logic [ID_W-1:0]       rsp_id;
`ifdef DSP_ARB_OVF_EN
  logic                  rsp_ovf;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign dsp_out = dsp_add_sub ? (dsp_in1 - dsp_in2) : (dsp_in1 + dsp_in2);

  dsp_addsub_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .dsp_in1     (dsp_in1),
    .dsp_in2     (dsp_in2),
    .dsp_add_sub (dsp_add_sub),
    .dsp_out     (dsp_out),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_id      (rsp_id)
`ifdef DSP_ARB_OVF_EN
    ,
    .rsp_ovf     (rsp_ovf)
`endif
  );

  typedef struct {
    string       name;
    int          id;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_data;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_req(input int id, input logic op, input logic [31:0] a,
                         input logic [31:0] b);
    req_op[id]         = op;
    req_a[id*32 +: 32] = a;
    req_b[id*32 +: 32] = b;
  endtask

  // Entered at a negedge with the DUT idle and rsp_ready low.
  task automatic run_vec(input vec_t v);
    logic [NUM_REQ-1:0] onehot;
    onehot = '0;
    onehot[v.id] = 1'b1;
    set_req(v.id, v.op, v.a, v.b);
    req_valid = onehot;
    #1 chk({v.name, " req_ready"}, req_ready, onehot);
    @(negedge clk);
    req_valid = '0;
    chk({v.name, " dsp_in1"}, dsp_in1, v.a);
    chk({v.name, " dsp_in2"}, dsp_in2, v.b);
    chk({v.name, " dsp_add_sub"}, dsp_add_sub, v.op);
    chk({v.name, " issue rsp_valid"}, rsp_valid, 0);
    @(negedge clk);
    chk({v.name, " rsp_valid"}, rsp_valid, 1);
    chk({v.name, " rsp_data"}, rsp_data, v.exp_data);
    chk({v.name, " rsp_id"}, rsp_id, v.id);
`ifdef DSP_ARB_OVF_EN
    chk({v.name, " rsp_ovf"}, rsp_ovf, v.exp_ovf);
`endif
    $display("txn %s id=%0d op=%0d a=%08h b=%08h data=%08h", v.name, v.id, v.op,
             v.a, v.b, rsp_data);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({v.name, " rsp_valid drop"}, rsp_valid, 0);
  endtask

  initial begin
    vecs[0] = '{"add0",     0, 1'b0, 32'd1,          32'd2,          32'd3,          1'b0};
    vecs[1] = '{"sub2",     2, 1'b1, 32'd5,          32'd7,          32'hFFFF_FFFE,  1'b0};
    vecs[2] = '{"wrap1",    1, 1'b0, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0};
    vecs[3] = '{"sub3",     3, 1'b1, 32'd0,          32'd1,          32'hFFFF_FFFF,  1'b0};
    vecs[4] = '{"add1",     1, 1'b0, 32'h1234_5678,  32'h1111_1111,  32'h2345_6789,  1'b0};
    vecs[5] = '{"ovf_add0", 0, 1'b0, 32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  1'b1};
    vecs[6] = '{"ovf_sub2", 2, 1'b1, 32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  1'b1};
    vecs[7] = '{"nov_sub3", 3, 1'b1, 32'd3,          32'd1,          32'd2,          1'b0};

    // Reset with every requester asking: nothing may be accepted.
    rst = 1'b1;
    req_valid = '1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst req_ready", req_ready, 0);
    chk("rst rsp_valid", rsp_valid, 0);
    chk("rst rsp_data", rsp_data, 0);
    chk("rst rsp_id", rsp_id, 0);
    chk("rst dsp_in1", dsp_in1, 0);
    chk("rst dsp_add_sub", dsp_add_sub, 0);
`ifdef DSP_ARB_OVF_EN
    chk("rst rsp_ovf", rsp_ovf, 0);
`endif
    req_valid = '0;
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i]);
    end

    // Reset during ISSUE: the in-flight op is dropped and ptr returns to 0.
    set_req(2, 1'b1, 32'd9, 32'd4);
    req_valid = 4'b0100;
    #1 chk("rstiss req_ready", req_ready, 4'b0100);
    @(negedge clk);
    chk("rstiss dsp_add_sub", dsp_add_sub, 1);
    req_valid = '1;
    rst = 1'b1;
    #1 chk("rstiss ready gated", req_ready, 0);
    @(negedge clk);
    chk("rstiss rsp_valid", rsp_valid, 0);
    chk("rstiss dsp_in1", dsp_in1, 0);
    rst = 1'b0;
    $display("txn reset_in_issue rsp_valid=%0d", rsp_valid);

    // All four requesters held valid with rsp_ready high: grants 0,1,2,3,0.
    for (int i = 0; i < NUM_REQ; i++) begin
      set_req(i, 1'b0, 32'(100 + i), 32'(i));
    end
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      logic [NUM_REQ-1:0] exp_gnt;
      exp_gnt = '0;
      exp_gnt[k % NUM_REQ] = 1'b1;
      #1 chk($sformatf("rr%0d req_ready", k), req_ready, exp_gnt);
      if (k > 0) begin
        chk($sformatf("rr%0d rsp_valid", k), rsp_valid, 1);
        chk($sformatf("rr%0d rsp_id", k), rsp_id, (k - 1) % NUM_REQ);
        chk($sformatf("rr%0d rsp_data", k), rsp_data, 32'(100 + 2 * ((k - 1) % NUM_REQ)));
      end
      $display("txn rr grant=%0d req_ready=%b", k % NUM_REQ, req_ready);
      @(negedge clk);
      chk($sformatf("rr%0d issue req_ready", k), req_ready, 0);
      chk($sformatf("rr%0d issue rsp_valid", k), rsp_valid, 0);
      chk($sformatf("rr%0d dsp_in1", k), dsp_in1, 32'(100 + k % NUM_REQ));
      if (k == 4) begin
        req_valid = '0;
        rsp_ready = 1'b0;
      end
      @(negedge clk);
    end

    // Backpressure: response from req0 held while req1 waits.
    set_req(1, 1'b1, 32'h0000_1000, 32'h0000_0010);
    req_valid = 4'b0010;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("bp%0d rsp_valid", c), rsp_valid, 1);
      chk($sformatf("bp%0d rsp_data", c), rsp_data, 32'd100);
      chk($sformatf("bp%0d rsp_id", c), rsp_id, 0);
      chk($sformatf("bp%0d req_ready", c), req_ready, 0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1 chk("bp release req_ready", req_ready, 4'b0010);
    $display("txn backpressure release req_ready=%b", req_ready);
    @(negedge clk);
    req_valid = '0;
    rsp_ready = 1'b0;
    chk("bp issue rsp_valid", rsp_valid, 0);
    chk("bp issue dsp_add_sub", dsp_add_sub, 1);
    @(negedge clk);
    chk("bp rsp_valid", rsp_valid, 1);
    chk("bp rsp_data", rsp_data, 32'h0000_0FF0);
    chk("bp rsp_id", rsp_id, 1);
    $display("txn bp id=%0d data=%08h", rsp_id, rsp_data);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp done rsp_valid", rsp_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
